// File: rtl/mult_pkg.sv
// Shared types and helpers for the serial add-shift multiplier.
package mult_pkg;

    typedef enum logic [2:0] {IDLE, ADD, SHIFT, STEP, HOLD} mult_state_t;

    // Elaboration-time ceil(log2(n)), used to size the bit counter
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/run_sync_edge.sv
// Two-flop synchroniser for an asynchronous pushbutton, plus a one-cycle rising-edge pulse.
module run_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic lvl,
    output logic rise
);

    logic meta, sync, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
        end
    end

    assign lvl  = sync;
    assign rise = sync & ~prev;

endmodule

// File: rtl/serial_mult_param.sv
// Signed add-shift serial multiplier; product is {X,A,B} after WIDTH bit steps,
// either as separate ADD/SHIFT cycles or one combined STEP cycle per bit.
module serial_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit SPLIT_STEPS = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load_Clr_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_t      state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             x_q;
    logic [CW-1:0]    cnt;
    logic             run_lvl, run_rise;

    logic [WIDTH:0]   opa, ops, sum;
    logic             nx;
    logic [WIDTH-1:0] na;

    run_sync_edge u_run (
        .clk   (Clk),
        .rst_n (Reset_n),
        .btn   (run_i),
        .lvl   (run_lvl),
        .rise  (run_rise)
    );

    // The multiplier's sign bit has negative weight, so the last partial product subtracts
    always_comb begin
        opa = {a_q[WIDTH-1], a_q};
        ops = {sw_i[WIDTH-1], sw_i};
        sum = (cnt == LAST) ? (opa - ops) : (opa + ops);
        nx  = b_q[0] ? sum[WIDTH] : x_q;
        na  = b_q[0] ? sum[WIDTH-1:0] : a_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            x_q    <= 1'b0;
            cnt    <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load_Clr_i) begin
                        b_q <= sw_i;
                        a_q <= '0;
                        x_q <= 1'b0;
                    end else if (run_rise) begin
                        a_q   <= '0;
                        x_q   <= 1'b0;
                        cnt   <= '0;
                        state <= SPLIT_STEPS ? ADD : STEP;
                    end
                end
                ADD: begin
                    x_q   <= nx;
                    a_q   <= na;
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_q <= {x_q, a_q[WIDTH-1:1]};
                    b_q <= {a_q[0], b_q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        done_o <= 1'b1;
                        state  <= HOLD;
                    end else begin
                        state <= ADD;
                    end
                end
                STEP: begin
                    x_q <= nx;
                    a_q <= {nx, na[WIDTH-1:1]};
                    b_q <= {na[0], b_q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        done_o <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (!run_lvl) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state == ADD) || (state == SHIFT) || (state == STEP);
    assign Aval   = a_q;
    assign Bval   = b_q;
    assign Xval   = x_q;

endmodule

// File: tb/tb_serial_mult_param.sv
// Scoreboard bench: split (dut0) and single-cycle (dut1) multipliers share stimulus;
// expected {X,A,B} results are queued per DUT and checked whenever done_o fires.
module tb_serial_mult_param;

    logic       Clk = 1'b0, Reset_n = 1'b0, Load_Clr_i = 1'b0, run_i = 1'b0;
    logic [7:0] sw_i = 8'h00;
    logic [7:0] a0, b0, a1, b1;
    logic       x0, x1, bz0, bz1, dn0, dn1;

    int          total = 0, bad = 0;
    logic [16:0] q0[$], q1[$];
    int          bc[2];
    logic        pd[2];

    always #5 Clk = ~Clk;

    serial_mult_param #(.WIDTH(8), .SPLIT_STEPS(1'b1)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Load_Clr_i(Load_Clr_i), .run_i(run_i), .sw_i(sw_i),
        .Aval(a0), .Bval(b0), .Xval(x0), .busy_o(bz0), .done_o(dn0));

    serial_mult_param #(.WIDTH(8), .SPLIT_STEPS(1'b0)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Load_Clr_i(Load_Clr_i), .run_i(run_i), .sw_i(sw_i),
        .Aval(a1), .Bval(b1), .Xval(x1), .busy_o(bz1), .done_o(dn1));

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic dn, input logic bz, input logic [16:0] res);
        logic [16:0] e;
        if (bz) bc[k]++;
        if (dn) begin
            chk($sformatf("done_single_cycle%0d", k), {16'b0, pd[k]}, 17'd0);
            if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL unexpected_done%0d act=%h exp=none", k, res);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("result%0d", k), res, e);
                chk($sformatf("busy_len%0d", k), 17'(bc[k]), (k == 0) ? 17'd16 : 17'd8);
            end
            bc[k] = 0;
        end
        pd[k] = dn;
    endtask

    always @(negedge Clk) begin
        if (!Reset_n) begin
            bc[0] = 0;
            bc[1] = 0;
        end
        mon(0, dn0, bz0, {x0, a0, b0});
        mon(1, dn1, bz1, {x1, a1, b1});
    end

    task automatic push(input logic [16:0] e);
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic load(input logic [7:0] v);
        sw_i       = v;
        Load_Clr_i = 1'b1;
        @(posedge Clk); #1;
        Load_Clr_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(posedge Clk);
            n++;
        end
        #1;
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout q0=%0d q1=%0d exp=0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic do_run(input logic [7:0] s, input logic [16:0] e, input int hold);
        push(e);
        sw_i  = s;
        run_i = 1'b1;
        drain();
        repeat (hold) @(posedge Clk);
        #1;
        run_i = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!bz0 && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("wait_busy", {16'b0, bz0}, 17'd1);
    endtask

    initial begin
        bc[0] = 0; bc[1] = 0; pd[0] = 1'b0; pd[1] = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_state0", {x0, a0, b0}, 17'h0);
        chk("reset_state1", {x1, a1, b1}, 17'h0);
        chk("reset_flags", {13'b0, bz0, bz1, dn0, dn1}, 17'h0);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk); #1;

        // 7 * 3, then keep the low half and multiply by 2 with run held long
        load(8'h07);
        chk("load_b", {1'b0, b0, b1}, {1'b0, 8'h07, 8'h07});
        do_run(8'h03, 17'h00015, 0);
        do_run(8'h02, 17'h0002A, 50);

        load(8'h07);
        do_run(8'hFD, 17'h1FFEB, 0);

        load(8'h80);
        do_run(8'h80, 17'h04000, 0);

        // abort mid-operation: outputs clear at once, no done_o follows
        load(8'h05);
        sw_i  = 8'h03;
        run_i = 1'b1;
        wait_busy();
        repeat (4) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("abort_state0", {x0, a0, b0}, 17'h0);
        chk("abort_state1", {x1, a1, b1}, 17'h0);
        chk("abort_busy", {15'b0, bz0, bz1}, 17'h0);
        repeat (2) @(posedge Clk);
        #1;
        run_i   = 1'b0;
        Reset_n = 1'b1;
        repeat (5) @(posedge Clk); #1;

        // Load_Clr while busy must not disturb B
        load(8'h05);
        push(17'h0000F);
        sw_i  = 8'h03;
        run_i = 1'b1;
        wait_busy();
        Load_Clr_i = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Load_Clr_i = 1'b0;
        drain();
        run_i = 1'b0;
        repeat (5) @(posedge Clk); #1;

        // load and run edge together: load wins, no start
        sw_i       = 8'h09;
        Load_Clr_i = 1'b1;
        run_i      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            chk($sformatf("no_start%0d", i), {15'b0, bz0, bz1}, 17'h0);
        end
        Load_Clr_i = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        chk("no_start_held", {15'b0, bz0, bz1}, 17'h0);
        chk("load_wins_b", {1'b0, b0, b1}, {1'b0, 8'h09, 8'h09});
        run_i = 1'b0;
        repeat (4) @(posedge Clk); #1;
        do_run(8'h02, 17'h00012, 0);

        repeat (5) @(posedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
